// File: rtl/gray_count_rx.sv
// Receive side of a gray count bus: samples, decodes to binary and classifies each step.
// Optional GRAY_SYNC_EN adds a two-flop synchronizer ahead of the capture register.
module gray_count_rx #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] gray_in,
  output logic [N-1:0] bin_out,
  output logic         valid,
  output logic         up,
  output logic         dn,
  output logic         wrap,
  output logic         err,
  output logic [7:0]   err_cnt
);

`ifdef GRAY_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif
  localparam logic [1:0]   ACQ_LAST = 2'(D);
  localparam logic [N-1:0] ONE      = N'(1);

  typedef enum logic [1:0] {ST_ACQ, ST_TRACK, ST_FAULT} state_t;

  state_t              state_q, state_d;
  logic [D-1:0][N-1:0] stage_q;
  logic [N-1:0]        g_s;
  logic [N-1:0]        g_p_q, g_p_d;
  logic [N-1:0]        bin_q, bin_d;
  logic [N-1:0]        b_s, b_p, diff;
  logic [1:0]          acq_q, acq_d;
  logic [1:0]          good_q, good_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                valid_q, valid_d;
  logic                up_q, up_d, dn_q, dn_d, wrap_q, wrap_d, err_q, err_d;
  logic                one_bit, multi_bit;

  assign g_s = stage_q[D-1];

  // Each binary bit is the parity of the gray bits at and above it.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dec
      assign b_s[gi] = ^g_s[N-1:gi];
      assign b_p[gi] = ^g_p_q[N-1:gi];
    end
  endgenerate

  assign diff      = g_s ^ g_p_q;
  assign one_bit   = (diff != '0) && ((diff & (diff - ONE)) == '0);
  assign multi_bit = (diff != '0) && !one_bit;

  always_comb begin
    state_d   = state_q;
    acq_d     = acq_q;
    good_d    = good_q;
    g_p_d     = g_p_q;
    bin_d     = bin_q;
    valid_d   = valid_q;
    err_cnt_d = err_cnt_q;
    up_d      = 1'b0;
    dn_d      = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_ACQ: begin
        acq_d = acq_q + 2'd1;
        if (acq_q == ACQ_LAST) begin
          g_p_d   = g_s;
          bin_d   = b_s;
          valid_d = 1'b1;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        g_p_d = g_s;
        bin_d = b_s;
        if (one_bit) begin
          if (b_s == b_p + ONE) begin
            up_d   = 1'b1;
            wrap_d = (b_s == '0);
          end else begin
            dn_d   = 1'b1;
            wrap_d = (b_s == '1);
          end
        end else if (multi_bit) begin
          err_d     = 1'b1;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          valid_d   = 1'b0;
          good_d    = 2'd0;
          state_d   = ST_FAULT;
        end
      end
      ST_FAULT: begin
        g_p_d = g_s;
        bin_d = b_s;
        // Two legal steps in a row (holds allowed between them) re-lock the tracker.
        if (one_bit) begin
          if (good_q == 2'd1) begin
            good_d  = 2'd0;
            valid_d = 1'b1;
            state_d = ST_TRACK;
          end else begin
            good_d = good_q + 2'd1;
          end
        end else if (multi_bit) begin
          err_d     = 1'b1;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          good_d    = 2'd0;
        end
      end
      default: state_d = ST_ACQ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_q   <= '0;
      state_q   <= ST_ACQ;
      acq_q     <= 2'd0;
      good_q    <= 2'd0;
      g_p_q     <= '0;
      bin_q     <= '0;
      valid_q   <= 1'b0;
      err_cnt_q <= 8'd0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      stage_q[0] <= gray_in;
      for (int k = 1; k < D; k++) stage_q[k] <= stage_q[k-1];
      state_q   <= state_d;
      acq_q     <= acq_d;
      good_q    <= good_d;
      g_p_q     <= g_p_d;
      bin_q     <= bin_d;
      valid_q   <= valid_d;
      err_cnt_q <= err_cnt_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign valid   = valid_q;
  assign up      = up_q;
  assign dn      = dn_q;
  assign wrap    = wrap_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule
